dl2_mem_bridge: RTL and testbench

DL2_MEM_BRIDGE -- requirements
Module: dl2_mem_bridge

---
 rtl/dl2_mem_bridge_pkg.sv | 22 ++
 rtl/dl2_mem_bridge_if.sv | 43 ++++
 rtl/dl2_mem_bridge.sv | 163 ++++++++++++++++
 tb/tb_dl2_mem_bridge.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dl2_mem_bridge_pkg.sv
// Shared cache-hierarchy defaults and the L2 memory bridge state encoding.
package dl2_mem_bridge_pkg;

  localparam int unsigned DL2_DADDR_BITS = 32;
  localparam int unsigned DL2_LINE_BITS  = 512;
  localparam int unsigned DL2_SUBBLOCKS  = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_REQ = 3'd1,
    ST_WR_CAP = 3'd2,
    ST_WR_REQ = 3'd3,
    ST_DONE   = 3'd4
  } dl2_state_e;

  // Byte stride between consecutive beats of one line.
  function automatic int unsigned dl2_beat_bytes(input int unsigned line_bits,
                                                 input int unsigned subblocks);
    return line_bits / subblocks / 8;
  endfunction

endpackage

// File: rtl/dl2_mem_bridge_if.sv
// L2 line port plus single-beat memory port of the L2 memory bridge.
interface dl2_mem_bridge_if #(
  parameter int unsigned DADDR_BITS = dl2_mem_bridge_pkg::DL2_DADDR_BITS,
  parameter int unsigned LINE_BITS  = dl2_mem_bridge_pkg::DL2_LINE_BITS,
  parameter int unsigned SUBBLOCKS  = dl2_mem_bridge_pkg::DL2_SUBBLOCKS
) ();

  localparam int unsigned BEAT_BITS = LINE_BITS / SUBBLOCKS;
  localparam int unsigned SB_LOG2   = $clog2(SUBBLOCKS);

  logic [DADDR_BITS-1:0] addrD;
  logic                  enD;
  logic                  weD;
  logic [BEAT_BITS-1:0]  doutD;
  logic [SB_LOG2-1:0]    doutDstrobe;
  logic [BEAT_BITS-1:0]  dinD;
  logic [SB_LOG2-1:0]    dinDstrobe;
  logic                  accR;
  logic                  accW;
  logic                  readyD;

  logic [DADDR_BITS-1:0] mem_addr;
  logic                  mem_req;
  logic                  mem_we;
  logic [BEAT_BITS-1:0]  mem_wdata;
  logic [BEAT_BITS-1:0]  mem_rdata;
  logic                  mem_ack;

  // Bridge side.
  modport slave (
    input  addrD, enD, weD, doutD, doutDstrobe, mem_rdata, mem_ack,
    output dinD, dinDstrobe, accR, accW, readyD,
           mem_addr, mem_req, mem_we, mem_wdata
  );

  // Cache / memory environment side.
  modport master (
    output addrD, enD, weD, doutD, doutDstrobe, mem_rdata, mem_ack,
    input  dinD, dinDstrobe, accR, accW, readyD,
           mem_addr, mem_req, mem_we, mem_wdata
  );

endinterface

// File: rtl/dl2_mem_bridge.sv
// Splits L2 line fills/writebacks into SUBBLOCKS single-beat memory transfers.
module dl2_mem_bridge
  import dl2_mem_bridge_pkg::*;
#(
  parameter int unsigned DADDR_BITS = DL2_DADDR_BITS,
  parameter int unsigned LINE_BITS  = DL2_LINE_BITS,
  parameter int unsigned SUBBLOCKS  = DL2_SUBBLOCKS
) (
  input  logic            clk,
  input  logic            reset,
  dl2_mem_bridge_if.slave bus
);

  localparam int unsigned BEAT_BITS  = LINE_BITS / SUBBLOCKS;
  localparam int unsigned SB_LOG2    = $clog2(SUBBLOCKS);
  localparam int unsigned BEAT_BYTES = dl2_beat_bytes(LINE_BITS, SUBBLOCKS);
  localparam int unsigned LINE_BYTES = LINE_BITS / 8;

  localparam logic [DADDR_BITS-1:0] LINE_MASK = ~(DADDR_BITS'(LINE_BYTES - 1));
  localparam logic [SB_LOG2-1:0]    LAST_BEAT = SB_LOG2'(SUBBLOCKS - 1);
  localparam logic [SB_LOG2-1:0]    BEAT_ONE  = SB_LOG2'(1);

  dl2_state_e            state_q, state_d;
  logic [DADDR_BITS-1:0] base_q, base_d;
  logic [SB_LOG2-1:0]    beat_q, beat_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [DADDR_BITS-1:0] mem_addr_q, mem_addr_d;
  logic [BEAT_BITS-1:0]  mem_wdata_q, mem_wdata_d;
  logic [BEAT_BITS-1:0]  din_q, din_d;
  logic [SB_LOG2-1:0]    din_strobe_q, din_strobe_d;
  logic                  acc_r_q, acc_r_d;
  logic                  acc_w_q, acc_w_d;
  logic                  ready_q, ready_d;
  logic                  ack_c;

  function automatic logic [DADDR_BITS-1:0] beat_addr(input logic [DADDR_BITS-1:0] base,
                                                      input logic [SB_LOG2-1:0]    beat);
    return base + (DADDR_BITS'(beat) * DADDR_BITS'(BEAT_BYTES));
  endfunction

  // An ack only counts while a request is actually outstanding.
  assign ack_c = bus.mem_ack & mem_req_q;

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    beat_d       = beat_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    din_d        = din_q;
    din_strobe_d = din_strobe_q;
    acc_r_d      = 1'b0;
    acc_w_d      = 1'b0;
    ready_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.weD) begin
          state_d = ST_WR_CAP;
          base_d  = bus.addrD & LINE_MASK;
          beat_d  = '0;
        end else if (bus.enD) begin
          state_d    = ST_RD_REQ;
          base_d     = bus.addrD & LINE_MASK;
          beat_d     = '0;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = bus.addrD & LINE_MASK;
        end
      end

      // Back-to-back beats: the next request is presented right after each ack.
      ST_RD_REQ: begin
        if (ack_c) begin
          din_d        = bus.mem_rdata;
          din_strobe_d = beat_q;
          acc_r_d      = 1'b1;
          beat_d       = beat_q + BEAT_ONE;
          if (beat_q == LAST_BEAT) begin
            state_d   = ST_DONE;
            mem_req_d = 1'b0;
            ready_d   = 1'b1;
          end else begin
            mem_addr_d = beat_addr(base_q, beat_q + BEAT_ONE);
          end
        end
      end

      ST_WR_CAP: begin
        if (bus.doutDstrobe == beat_q) begin
          mem_wdata_d = bus.doutD;
          acc_w_d     = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = beat_addr(base_q, beat_q);
          state_d     = ST_WR_REQ;
        end
      end

      ST_WR_REQ: begin
        if (ack_c) begin
          beat_d    = beat_q + BEAT_ONE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (beat_q == LAST_BEAT) begin
            state_d = ST_DONE;
            ready_d = 1'b1;
          end else begin
            state_d = ST_WR_CAP;
          end
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      base_q       <= '0;
      beat_q       <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      din_q        <= '0;
      din_strobe_q <= '0;
      acc_r_q      <= 1'b0;
      acc_w_q      <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      beat_q       <= beat_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      din_q        <= din_d;
      din_strobe_q <= din_strobe_d;
      acc_r_q      <= acc_r_d;
      acc_w_q      <= acc_w_d;
      ready_q      <= ready_d;
    end
  end

  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.dinD       = din_q;
  assign bus.dinDstrobe = din_strobe_q;
  assign bus.accR       = acc_r_q;
  assign bus.accW       = acc_w_q;
  assign bus.readyD     = ready_q;

endmodule

// File: tb/tb_dl2_mem_bridge.sv
// Self-checking bench for dl2_mem_bridge: vector table, corner sequences, random lines.
module tb_dl2_mem_bridge;

  localparam int AW = 32;
  localparam int LB = 512;
  localparam int SB = 4;
  localparam int BW = LB / SB;
  localparam int BEAT_B = BW / 8;
  localparam int LINE_B = LB / 8;

  logic clk;
  logic reset;

  dl2_mem_bridge_if #(.DADDR_BITS(AW), .LINE_BITS(LB), .SUBBLOCKS(SB)) bus ();

  dl2_mem_bridge #(.DADDR_BITS(AW), .LINE_BITS(LB), .SUBBLOCKS(SB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [BW-1:0] wdata;
    int            cyc;
  } beat_t;

  typedef struct {
    logic [1:0]    strobe;
    logic [BW-1:0] data;
  } fill_t;

  typedef struct {
    bit            wr;
    bit            rd;
    logic [AW-1:0] addr;
    int            lat;
    logic [7:0]    dseed;
    logic [AW-1:0] exp_base;
    bit            exp_we;
    int            exp_cyc;
  } vec_t;

  beat_t beat_log[$];
  fill_t fill_log[$];
  int acc_w_cnt, ready_cnt, req_cnt, stab_errs;
  int ack_lat, wait_cnt, req_cycles;
  bit hold_valid;
  logic [AW-1:0] hold_addr;
  logic          hold_we;
  logic [BW-1:0] hold_wdata;

  logic [BW-1:0] phys    [logic [AW-1:0]];
  logic [BW-1:0] ref_mem [logic [AW-1:0]];
  logic [BW-1:0] wb_line [SB];

  int n_checks = 0;
  int n_err = 0;

  function automatic logic [BW-1:0] pattern(input logic [AW-1:0] a);
    return {a, a ^ 32'hDEAD_BEEF, ~a, a + 32'h1234_5678};
  endfunction

  function automatic logic [BW-1:0] phys_read(input logic [AW-1:0] a);
    if (phys.exists(a)) return phys[a];
    return pattern(a);
  endfunction

  function automatic logic [BW-1:0] ref_read(input logic [AW-1:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return pattern(a);
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " accR"}, bus.accR, 0);
    check({tag, " accW"}, bus.accW, 0);
    check({tag, " readyD"}, bus.readyD, 0);
    check({tag, " mem_req"}, bus.mem_req, 0);
    check({tag, " mem_we"}, bus.mem_we, 0);
    check({tag, " mem_addr"}, bus.mem_addr, 0);
    check({tag, " mem_wdata"}, bus.mem_wdata, 0);
    check({tag, " dinD"}, bus.dinD, 0);
    check({tag, " dinDstrobe"}, bus.dinDstrobe, 0);
  endtask

  // Memory responder and output monitor; ack latency counts cycles of mem_req before ack.
  always @(negedge clk) begin
    if (!reset) begin
      bus.mem_ack = 1'b0;
      wait_cnt    = 0;
      req_cycles  = 0;
      hold_valid  = 1'b0;
    end else begin
      if (bus.accR) fill_log.push_back('{bus.dinDstrobe, bus.dinD});
      if (bus.accW) acc_w_cnt++;
      if (bus.readyD) ready_cnt++;
      if (bus.mem_req) begin
        req_cnt++;
        req_cycles++;
        if (hold_valid && (bus.mem_addr !== hold_addr || bus.mem_we !== hold_we ||
                           bus.mem_wdata !== hold_wdata))
          stab_errs++;
        if (wait_cnt >= ack_lat) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = phys_read(bus.mem_addr);
          beat_log.push_back('{bus.mem_addr, bus.mem_we, bus.mem_wdata, req_cycles});
          if (bus.mem_we) phys[bus.mem_addr] = bus.mem_wdata;
          wait_cnt   = 0;
          req_cycles = 0;
          hold_valid = 1'b0;
        end else begin
          bus.mem_ack = 1'b0;
          wait_cnt++;
          hold_valid  = 1'b1;
          hold_addr   = bus.mem_addr;
          hold_we     = bus.mem_we;
          hold_wdata  = bus.mem_wdata;
        end
      end else begin
        // Spurious acks with no request outstanding must have no effect.
        bus.mem_ack   = 1'($urandom_range(0, 1));
        bus.mem_rdata = {$urandom, $urandom, $urandom, $urandom};
        wait_cnt      = 0;
        req_cycles    = 0;
        hold_valid    = 1'b0;
      end
    end
  end

  task automatic do_txn(input string tag, input bit wr, input bit rd, input logic [AW-1:0] addr,
                        input int lat, input int stall, input bit scramble,
                        input logic [AW-1:0] exp_base, input bit exp_we, input int exp_cyc);
    logic [BW-1:0] exp_rd [SB];
    int  k;
    bit  done;
    int  n;
    for (int b = 0; b < SB; b++) exp_rd[b] = ref_read(exp_base + AW'(b * BEAT_B));
    step();
    beat_log.delete();
    fill_log.delete();
    acc_w_cnt = 0;
    ready_cnt = 0;
    req_cnt   = 0;
    stab_errs = 0;
    ack_lat   = lat;
    k         = 0;
    bus.addrD = addr;
    bus.enD   = rd;
    bus.weD   = wr;
    if (stall > 0) begin
      bus.doutDstrobe = 2'd2;
      bus.doutD       = '1;
      repeat (stall) step();
      check({tag, " stall accW"}, acc_w_cnt, 0);
      check({tag, " stall mem_req"}, req_cnt, 0);
    end
    bus.doutDstrobe = 2'd0;
    bus.doutD       = wb_line[0];
    done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      step();
      if (scramble) bus.addrD = $urandom;
      if (wr && bus.accW) begin
        k++;
        bus.doutDstrobe = 2'(k);
        bus.doutD       = (k < SB) ? wb_line[k] : {$urandom, $urandom, $urandom, $urandom};
      end
      if (bus.readyD) begin
        bus.enD = 1'b0;
        bus.weD = 1'b0;
        done    = 1'b1;
      end
    end
    if (!done) begin
      bus.enD = 1'b0;
      bus.weD = 1'b0;
    end
    repeat (3) step();
    check({tag, " completed"}, done, 1);
    check({tag, " readyD count"}, ready_cnt, 1);
    check({tag, " beat count"}, beat_log.size(), SB);
    check({tag, " req stable"}, stab_errs, 0);
    n = (beat_log.size() < SB) ? beat_log.size() : SB;
    for (int b = 0; b < n; b++) begin
      check($sformatf("%s b%0d addr", tag, b), beat_log[b].addr, exp_base + AW'(b * BEAT_B));
      check($sformatf("%s b%0d we", tag, b), beat_log[b].we, exp_we);
      check($sformatf("%s b%0d req cycles", tag, b), beat_log[b].cyc, exp_cyc);
      if (exp_we) check($sformatf("%s b%0d wdata", tag, b), beat_log[b].wdata, wb_line[b]);
    end
    if (exp_we) begin
      check({tag, " accW count"}, acc_w_cnt, SB);
      check({tag, " accR count"}, fill_log.size(), 0);
      for (int b = 0; b < SB; b++) ref_mem[exp_base + AW'(b * BEAT_B)] = wb_line[b];
    end else begin
      check({tag, " accW count"}, acc_w_cnt, 0);
      check({tag, " accR count"}, fill_log.size(), SB);
      n = (fill_log.size() < SB) ? fill_log.size() : SB;
      for (int b = 0; b < n; b++) begin
        check($sformatf("%s f%0d strobe", tag, b), fill_log[b].strobe, b);
        check($sformatf("%s f%0d data", tag, b), fill_log[b].data, exp_rd[b]);
      end
    end
  endtask

  initial begin
    vec_t vt [7];
    bit   rwr;
    bit   rrd;
    logic [AW-1:0] raddr;
    int   rlat;
    bit   reached;

    clk             = 1'b0;
    reset           = 1'b1;
    bus.addrD       = '0;
    bus.enD         = 1'b0;
    bus.weD         = 1'b0;
    bus.doutD       = '0;
    bus.doutDstrobe = '0;
    bus.mem_ack     = 1'b0;
    bus.mem_rdata   = '0;
    ack_lat         = 0;

    #2 reset = 1'b0;
    #1 check_all_zero("reset");
    repeat (3) @(negedge clk);
    reset = 1'b1;

    vt[0] = '{0, 1, 32'h0000_1000, 0, 8'h00, 32'h0000_1000, 0, 1};
    vt[1] = '{1, 0, 32'h0000_2040, 0, 8'hA0, 32'h0000_2040, 1, 1};
    vt[2] = '{1, 1, 32'h0000_3000, 0, 8'h50, 32'h0000_3000, 1, 1};
    vt[3] = '{0, 1, 32'h0000_3000, 0, 8'h00, 32'h0000_3000, 0, 1};
    vt[4] = '{0, 1, 32'h0000_4000, 5, 8'h00, 32'h0000_4000, 0, 6};
    vt[5] = '{1, 0, 32'h0000_205F, 2, 8'hC0, 32'h0000_2040, 1, 3};
    vt[6] = '{0, 1, 32'hFFFF_FFE7, 1, 8'h00, 32'hFFFF_FFC0, 0, 2};
    for (int i = 0; i < 7; i++) begin
      for (int b = 0; b < SB; b++) wb_line[b] = BW'(vt[i].dseed) + BW'(b);
      do_txn($sformatf("vec%0d", i), vt[i].wr, vt[i].rd, vt[i].addr, vt[i].lat, 0, 0,
             vt[i].exp_base, vt[i].exp_we, vt[i].exp_cyc);
    end

    // Writeback whose first strobe is wrong for ten cycles.
    for (int b = 0; b < SB; b++) wb_line[b] = {$urandom, $urandom, $urandom, $urandom};
    do_txn("stall", 1, 0, 32'h0000_5000, 1, 10, 0, 32'h0000_5000, 1, 2);

    // Reset asserted while beat 2 of a fill is outstanding.
    step();
    fill_log.delete();
    ack_lat   = 3;
    bus.addrD = 32'h0000_6000;
    bus.enD   = 1'b1;
    reached   = 1'b0;
    for (int c = 0; c < 100 && !reached; c++) begin
      step();
      if (fill_log.size() >= 2) reached = 1'b1;
    end
    check("abort reached beat2", reached, 1);
    check("abort beat2 addr", bus.mem_addr, 32'h0000_6020);
    check("abort beat2 req", bus.mem_req, 1);
    #1 reset = 1'b0;
    #1 check_all_zero("abort");
    bus.enD = 1'b0;
    repeat (2) step();
    ready_cnt = 0;
    req_cnt   = 0;
    reset     = 1'b1;
    repeat (10) step();
    check("abort no readyD", ready_cnt, 0);
    check("abort idle no req", req_cnt, 0);
    do_txn("post_abort", 0, 1, 32'h0000_6000, 0, 0, 0, 32'h0000_6000, 0, 1);

    // Random lines against the line-level model, with addrD churn during each line.
    for (int i = 0; i < 40; i++) begin
      rwr   = 1'($urandom_range(0, 1));
      rrd   = rwr ? 1'($urandom_range(0, 1)) : 1'b1;
      raddr = (i % 3 == 0) ? (32'h0000_7000 + AW'((i % 4) * LINE_B) + AW'($urandom_range(0, 63)))
                           : $urandom;
      rlat  = $urandom_range(0, 3);
      for (int b = 0; b < SB; b++) wb_line[b] = {$urandom, $urandom, $urandom, $urandom};
      do_txn($sformatf("rnd%0d", i), rwr, rrd, raddr, rlat, 0, 1,
             raddr & ~AW'(LINE_B - 1), rwr, rlat + 1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
